// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data memory controller: access size codes,
// FSM state encoding and address alignment checks.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    function automatic logic [3:0] size_bytes(input size_e size);
        return 4'd1 << size;
    endfunction

    function automatic logic is_aligned(input logic [2:0] addr_lsb, input size_e size);
        logic ok;
        case (size)
            SZ_B:    ok = 1'b1;
            SZ_H:    ok = (addr_lsb[0] == 1'b0);
            SZ_W:    ok = (addr_lsb[1:0] == 2'b00);
            default: ok = (addr_lsb == 3'b000);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between the MEM stage (master) and the data memory (slave).
interface data_memory_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              init_busy;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byte enables/data shift and load shift/extend.
// Sign extension of sub-word loads is built only with DMEM_LOAD_EXT_EN defined.
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int NB     = DATA_W / 8,
    localparam int LANE_W = $clog2(NB)
) (
    input  size_e             size,
    input  logic [LANE_W-1:0] lane,
    input  logic [DATA_W-1:0] wdata,
    input  logic              sign_ext,
    input  logic [DATA_W-1:0] rword,
    output logic [NB-1:0]     be,
    output logic [DATA_W-1:0] wword,
    output logic [DATA_W-1:0] ld_data
);
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] keep_mask;

    assign be    = NB'((32'd1 << size_bytes(size)) - 32'd1) << lane;
    assign wword = wdata << {lane, 3'b000};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        shifted   = rword >> {lane, 3'b000};
        keep_mask = '1;
        case (size)
            SZ_B:    keep_mask = DATA_W'(8'hFF);
            SZ_H:    keep_mask = DATA_W'(16'hFFFF);
            SZ_W:    keep_mask = DATA_W'(32'hFFFF_FFFF);
            default: keep_mask = '1;
        endcase
    end

`ifdef DMEM_LOAD_EXT_EN
    logic sign_bit;

    always_comb begin
        sign_bit = 1'b0;
        case (size)
            SZ_B:    sign_bit = shifted[7];
            SZ_H:    sign_bit = shifted[15];
            SZ_W:    sign_bit = shifted[31];
            default: sign_bit = shifted[DATA_W-1];
        endcase
    end

    assign ld_data = (shifted & keep_mask) | ((sign_ext && sign_bit) ? ~keep_mask : '0);
`else
    logic unused_sign_ext;

    assign unused_sign_ext = sign_ext;
    assign ld_data         = shifted & keep_mask;
`endif

endmodule

// File: rtl/data_memory_ctrl.sv
// Byte-addressable little-endian data memory with a post-reset clear engine and
// a registered one-cycle response. Optional feature macro: DMEM_LOAD_EXT_EN.
module data_memory_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH_BYTES = 1024,
    parameter int ADDR_W      = 32
) (
    input logic                clk,
    input logic                rst_n,
    data_memory_ctrl_if.slave  bus
);
    localparam int NB     = DATA_W / 8;
    localparam int LANE_W = $clog2(NB);
    localparam int WORDS  = DEPTH_BYTES / NB;
    localparam int IDX_W  = $clog2(WORDS);
    localparam int BA_W   = $clog2(DEPTH_BYTES);

    state_e            state;
    logic [IDX_W-1:0]  init_ptr;
    logic [DATA_W-1:0] mem [WORDS];

    size_e             size;
    logic [IDX_W-1:0]  word_idx;
    logic [LANE_W-1:0] lane;
    logic              accept;
    logic              err;
    logic              commit;
    logic [NB-1:0]     wr_be;
    logic [DATA_W-1:0] wr_word;
    logic [DATA_W-1:0] ld_data;

    assign size     = size_e'(bus.req_size);
    assign word_idx = bus.req_addr[BA_W-1:LANE_W];
    assign lane     = bus.req_addr[LANE_W-1:0];
    assign accept   = bus.req_valid && bus.req_ready;

    // High address bits are never folded back into the array; any set bit faults.
    assign err = ((size == SZ_D) && (DATA_W == 32))
               || !is_aligned(bus.req_addr[2:0], size)
               || (|bus.req_addr[ADDR_W-1:BA_W]);
    assign commit = accept && bus.req_we && !err;

    dmem_lane_align #(.DATA_W(DATA_W)) u_lane_align (
        .size     (size),
        .lane     (lane),
        .wdata    (bus.req_wdata),
        .sign_ext (bus.req_signed),
        .rword    (mem[word_idx]),
        .be       (wr_be),
        .wword    (wr_word),
        .ld_data  (ld_data)
    );

    // NOTE: the storage array has no reset; the INIT engine clears it word by word.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[init_ptr] <= '0;
        end else if (commit) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_be[b]) mem[word_idx][8*b +: 8] <= wr_word[8*b +: 8];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_INIT;
            init_ptr      <= '0;
            bus.req_ready <= 1'b0;
            bus.init_busy <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= '0;
        end else begin
            bus.rsp_valid <= accept;
            bus.rsp_err   <= accept && err;
            bus.rsp_rdata <= (accept && !err && !bus.req_we) ? ld_data : '0;

            case (state)
                ST_INIT: begin
                    init_ptr <= init_ptr + 1'b1;
                    if (init_ptr == IDX_W'(WORDS - 1)) begin
                        state         <= ST_READY;
                        bus.req_ready <= 1'b1;
                        bus.init_busy <= 1'b0;
                    end
                end
                ST_READY: begin
                    bus.req_ready <= 1'b1;
                    bus.init_busy <= 1'b0;
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench for data_memory_ctrl: the driver queues expected responses,
// a negedge monitor pops and compares each rsp_valid beat.
module tb_data_memory_ctrl;
    import dmem_pkg::*;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    data_memory_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    data_memory_ctrl #(.DATA_W(DATA_W), .DEPTH_BYTES(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   rsp_n  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check($sformatf("rsp%0d_rdata", rsp_n), bus.rsp_rdata, e.rdata);
                check($sformatf("rsp%0d_err", rsp_n), {31'd0, bus.rsp_err}, {31'd0, e.err});
                rsp_n++;
            end
        end
    end

    task automatic issue(input logic we, input size_e sz, input logic sgn, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] exp_d, input logic exp_e);
        exp_t e;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = sz;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        check($sformatf("req_ready@%0h", addr), {31'd0, bus.req_ready}, 32'd1);
        e.rdata = exp_d;
        e.err   = exp_e;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int k = 0;
        bus.req_valid = 1'b0;
        while (sb.size() != 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("scoreboard_drained", sb.size(), 32'd0);
    endtask

    // Called on the negedge where rst_n is released; counts init_busy cycles.
    task automatic wait_init(input string tag);
        int n         = 0;
        int ready_bad = 0;
        while (bus.init_busy && n < 1000) begin
            if (bus.req_ready) ready_bad++;
            n++;
            @(negedge clk);
        end
        check({tag, "_init_cycles"}, n, 32'd256);
        check({tag, "_ready_during_init"}, ready_bad, 32'd0);
        check({tag, "_ready_after_init"}, {31'd0, bus.req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_size   = SZ_B;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;

        repeat (3) @(negedge clk);
        check("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("reset_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        check("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("reset_req_ready", {31'd0, bus.req_ready}, 32'd0);
        check("reset_init_busy", {31'd0, bus.init_busy}, 32'd1);
        rst_n = 1'b1;
        wait_init("boot");

        // Cleared memory, then word store with sub-word loads
        issue(1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'h0000_0000, 1'b0);
        issue(1'b1, SZ_W, 1'b0, 32'h20, 32'hDEAD_BEEF, 32'h0, 1'b0);
        issue(1'b0, SZ_B, 1'b0, 32'h23, 32'h0, 32'h0000_00DE, 1'b0);
        issue(1'b0, SZ_H, 1'b0, 32'h20, 32'h0, 32'h0000_BEEF, 1'b0);
        issue(1'b0, SZ_B, 1'b0, 32'h21, 32'h0, 32'h0000_00BE, 1'b0);

        // Partial stores leave other lanes untouched; only low wdata bits are used
        issue(1'b1, SZ_W, 1'b0, 32'h40, 32'h1122_3344, 32'h0, 1'b0);
        issue(1'b1, SZ_B, 1'b0, 32'h41, 32'hFFFF_FF7F, 32'h0, 1'b0);
        issue(1'b0, SZ_W, 1'b0, 32'h40, 32'h0, 32'h1122_7F44, 1'b0);
        issue(1'b1, SZ_H, 1'b0, 32'h42, 32'h1234_CAFE, 32'h0, 1'b0);
        issue(1'b0, SZ_W, 1'b0, 32'h40, 32'h0, 32'hCAFE_7F44, 1'b0);

        // Highest legal word
        issue(1'b1, SZ_W, 1'b0, 32'h3FC, 32'hA5A5_5A5A, 32'h0, 1'b0);
        issue(1'b0, SZ_B, 1'b0, 32'h3FF, 32'h0, 32'h0000_00A5, 1'b0);
        issue(1'b0, SZ_W, 1'b0, 32'h3FC, 32'h0, 32'hA5A5_5A5A, 1'b0);
        idle(2);

        // Faulting accesses: no write, rdata forced to zero
        issue(1'b0, SZ_H, 1'b0, 32'h21, 32'h0, 32'h0, 1'b1);
        issue(1'b1, SZ_W, 1'b0, 32'h42, 32'hFFFF_FFFF, 32'h0, 1'b1);
        issue(1'b0, SZ_W, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1);
        issue(1'b1, SZ_W, 1'b0, 32'h400, 32'h0BAD_F00D, 32'h0, 1'b1);
        issue(1'b1, SZ_W, 1'b0, 32'h8000_0020, 32'h0BAD_F00D, 32'h0, 1'b1);
        issue(1'b0, SZ_D, 1'b0, 32'h40, 32'h0, 32'h0, 1'b1);
        issue(1'b0, SZ_W, 1'b0, 32'h40, 32'h0, 32'hCAFE_7F44, 1'b0);
        issue(1'b0, SZ_W, 1'b0, 32'h20, 32'h0, 32'hDEAD_BEEF, 1'b0);
        issue(1'b0, SZ_W, 1'b0, 32'h0, 32'h0, 32'h0000_0000, 1'b0);
        idle(2);

        // Load extension
        issue(1'b1, SZ_W, 1'b0, 32'h0, 32'h0000_80F0, 32'h0, 1'b0);
`ifdef DMEM_LOAD_EXT_EN
        issue(1'b0, SZ_B, 1'b1, 32'h0, 32'h0, 32'hFFFF_FFF0, 1'b0);
        issue(1'b0, SZ_H, 1'b1, 32'h0, 32'h0, 32'hFFFF_80F0, 1'b0);
        issue(1'b0, SZ_B, 1'b0, 32'h0, 32'h0, 32'h0000_00F0, 1'b0);
        issue(1'b0, SZ_B, 1'b1, 32'h1, 32'h0, 32'hFFFF_FF80, 1'b0);
`else
        issue(1'b0, SZ_B, 1'b1, 32'h0, 32'h0, 32'h0000_00F0, 1'b0);
        issue(1'b0, SZ_H, 1'b1, 32'h0, 32'h0, 32'h0000_80F0, 1'b0);
        issue(1'b0, SZ_B, 1'b0, 32'h0, 32'h0, 32'h0000_00F0, 1'b0);
        issue(1'b0, SZ_B, 1'b1, 32'h1, 32'h0, 32'h0000_0080, 1'b0);
`endif
        issue(1'b0, SZ_H, 1'b1, 32'h2, 32'h0, 32'h0000_0000, 1'b0);

        // Back-to-back store then load of the same word
        issue(1'b1, SZ_W, 1'b0, 32'h80, 32'h1234_5678, 32'h0, 1'b0);
        issue(1'b0, SZ_W, 1'b0, 32'h80, 32'h0, 32'h1234_5678, 1'b0);
        drain();
        idle(2);

        // Reset while a load response is on the bus: response dropped, INIT restarts
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_size   = SZ_W;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'h80;
        @(posedge clk);
        #1;
        check("pre_reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("midrsp_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("midrsp_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("midrsp_req_ready", {31'd0, bus.req_ready}, 32'd0);
        check("midrsp_init_busy", {31'd0, bus.init_busy}, 32'd1);
        bus.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset again in the middle of INIT
        repeat (40) @(negedge clk);
        check("midinit_init_busy", {31'd0, bus.init_busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midinit_reset_busy", {31'd0, bus.init_busy}, 32'd1);
        check("midinit_reset_ready", {31'd0, bus.req_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_init("restart");

        issue(1'b0, SZ_W, 1'b0, 32'h80, 32'h0, 32'h0000_0000, 1'b0);
        issue(1'b0, SZ_W, 1'b0, 32'h20, 32'h0, 32'h0000_0000, 1'b0);
        issue(1'b0, SZ_W, 1'b0, 32'h40, 32'h0, 32'h0000_0000, 1'b0);
        issue(1'b0, SZ_W, 1'b0, 32'h3FC, 32'h0, 32'h0000_0000, 1'b0);
        drain();
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
